// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing constants for the sequential divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam int DIV_WIDTH_DEF = 16;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
    localparam int CNT_W_DEF = cnt_width(DIV_WIDTH_DEF);
endpackage

// File: rtl/div_datapath.sv
// div_datapath: restoring shift-subtract on magnitudes, sign fix-up and result registers
module div_datapath
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         iterate,
    input  logic         fix,
    input  logic         dz,
    input  logic         ov,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    logic [W-1:0] a, q, m, abs_dd, abs_ds;
    logic [W:0] a_sh, t;
    logic sign_q, sign_r;
    assign abs_dd = dividend[W-1] ? -dividend : dividend;
    assign abs_ds = divisor[W-1] ? -divisor : divisor;
    // a stays below m <= 2^(W-1), so the shifted partial remainder fits in W+1 bits
    assign a_sh = {a, q[W-1]};
    assign t = a_sh - {1'b0, m};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (load) begin
                a      <= '0;
                q      <= abs_dd;
                m      <= abs_ds;
                sign_q <= dividend[W-1] ^ divisor[W-1];
                sign_r <= dividend[W-1];
            end else if (iterate) begin
                a <= t[W] ? a_sh[W-1:0] : t[W-1:0];
                q <= {q[W-2:0], ~t[W]};
            end
            if (load && (dz || ov)) begin
                quotient    <= dz ? '1 : MIN;
                remainder   <= dz ? dividend : '0;
                div_by_zero <= dz;
                overflow    <= ov;
            end else if (fix) begin
                quotient    <= sign_q ? -q : q;
                remainder   <= sign_r ? -a : a;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: signed truncating divider with valid/ready operand and result handshakes
module seq_divider
    import div_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 dest_valid,
    input  logic                 dest_ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);
    localparam int CW = cnt_width(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic accept, dz, ov;
    assign src_ready  = state == IDLE;
    assign dest_valid = state == DONE;
    assign accept     = src_valid && src_ready;
    assign dz         = divisor == '0;
    assign ov         = dividend == MIN && divisor == '1;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((dz || ov) ? DONE : CALC) : IDLE;
            CALC:    state_n = (cnt == CW'(DIV_WIDTH - 1)) ? FIX : CALC;
            FIX:     state_n = DONE;
            DONE:    state_n = dest_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= accept ? '0 : (state == CALC ? cnt + 1'b1 : cnt);
        end
    end
    div_datapath #(.W(DIV_WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .iterate    (state == CALC),
        .fix        (state == FIX),
        .dz         (dz),
        .ov         (ov),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );
endmodule
